// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver, E0/F0 folding, FWFT scan-code FIFO.
// Optional: define PS2_RX_TIMEOUT_EN to abort stalled partial frames.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int DECODE_PREFIX  = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                         inclock,
    input  logic                         resetn,
    input  logic                         ps2_clock,
    input  logic                         ps2_data,
    input  logic                         rd_en,
    output logic                         rd_valid,
    output logic [9:0]                   rd_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [7:0]                   last_data_received,
    output logic                         overflow,
    output logic                         parity_err,
    output logic                         frame_err,
    input  logic                         err_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic       clk_prev, fall, din;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       par_bit;
    logic       ext, brk;
    logic       timeout;
    logic       stop_evt, par_ok, frame_ok;
    logic       is_e0, is_f0, push, pop, full, wr_ok;
    logic [9:0] push_data;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign din  = dat_sync[SYNC_STAGES-1];
    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn)
            to_cnt <= '0;
        else if (fall || state == IDLE)
            to_cnt <= '0;
        else if (!timeout)
            to_cnt <= to_cnt + TW'(1);
    end

    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));
`else
    // No watchdog: a partial frame waits for the next PS/2 edge forever.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (timeout) begin
            state_nx = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE:    if (!din) state_nx = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        stop_evt  = fall && (state == STOP) && !timeout;
        par_ok    = ^{shreg, par_bit};
        frame_ok  = stop_evt && par_ok && din;
        is_e0     = (DECODE_PREFIX != 0) && (shreg == 8'hE0);
        is_f0     = (DECODE_PREFIX != 0) && (shreg == 8'hF0);
        push      = frame_ok && !is_e0 && !is_f0;
        push_data = {ext, brk, shreg};
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else if (fall && !timeout) begin
            case (state)
                IDLE: bit_cnt <= '0;
                DATA: begin
                    shreg   <= {din, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                PARITY:  par_bit <= din;
                default: ;
            endcase
        end
    end

    // Prefix flags only ever set when folding is enabled (is_e0/is_f0).
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            ext                <= 1'b0;
            brk                <= 1'b0;
            last_data_received <= '0;
        end else if (frame_ok) begin
            last_data_received <= shreg;
            if (is_e0)
                ext <= 1'b1;
            else if (is_f0)
                brk <= 1'b1;
            else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    assign rd_valid = (fifo_count != '0);
    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign pop      = rd_en && rd_valid;
    assign wr_ok    = push && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge inclock) begin
        if (wr_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    // A fresh error in the clearing cycle keeps its flag set.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overflow   <= (overflow & ~err_clear)
                        | (push & full & ~pop);
            parity_err <= (parity_err & ~err_clear)
                        | (stop_evt & ~par_ok);
            frame_err  <= (frame_err & ~err_clear)
                        | (stop_evt & ~din) | timeout;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: scoreboard bench for ps2_rx_fifo (folding and raw).
// Timeout checks run only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int TO    = 300;
    localparam int HALF  = 8;

    logic       inclock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       rd_en_raw = 1'b0;
    logic       err_clear = 1'b0;

    logic       rd_valid, rd_valid_raw;
    logic [9:0] rd_data, rd_data_raw;
    logic [3:0] fifo_count, fifo_count_raw;
    logic [7:0] last_data_received, last_raw;
    logic       overflow, parity_err, frame_err;
    logic       ovf_raw, perr_raw, ferr_raw;

    int n_run = 0;
    int n_fail = 0;

    logic [9:0] sb[$];
    logic [9:0] sb_raw[$];
    bit m_ext = 0;
    bit m_brk = 0;
    bit raw_track = 1;

    ps2_rx_fifo #(
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2),
        .DECODE_PREFIX(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .inclock(inclock), .resetn(resetn),
        .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .fifo_count(fifo_count),
        .last_data_received(last_data_received),
        .overflow(overflow), .parity_err(parity_err),
        .frame_err(frame_err), .err_clear(err_clear)
    );

    ps2_rx_fifo #(
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2),
        .DECODE_PREFIX(0), .TIMEOUT_CYCLES(TO)
    ) dut_raw (
        .inclock(inclock), .resetn(resetn),
        .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .rd_en(rd_en_raw), .rd_valid(rd_valid_raw),
        .rd_data(rd_data_raw), .fifo_count(fifo_count_raw),
        .last_data_received(last_raw),
        .overflow(ovf_raw), .parity_err(perr_raw),
        .frame_err(ferr_raw), .err_clear(err_clear)
    );

    always #5 inclock = ~inclock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input bit pop_at_fall);
        @(negedge inclock);
        ps2_data = b;
        repeat (HALF) @(negedge inclock);
        ps2_clock = 1'b0;
        if (pop_at_fall) begin
            // rd_en lands on the cycle the stop edge is detected
            repeat (2) @(negedge inclock);
            chk("full_valid", rd_valid, 1);
            chk("full_head", rd_data, sb.pop_front());
            rd_en = 1'b1;
            @(negedge inclock);
            rd_en = 1'b0;
            repeat (HALF - 3) @(negedge inclock);
        end else begin
            repeat (HALF) @(negedge inclock);
        end
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                              input logic stop = 1'b1, input int nbits = 11,
                              input bit pop_at_stop = 0);
        logic [10:0] fr;
        fr = {stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(fr[i], pop_at_stop && (i == 10));
        repeat (4) @(negedge inclock);
        if (nbits == 11 && !bad_par && stop) begin
            if (raw_track && sb_raw.size() < DEPTH)
                sb_raw.push_back({2'b00, b});
            if (b == 8'hE0)
                m_ext = 1;
            else if (b == 8'hF0)
                m_brk = 1;
            else begin
                if (sb.size() < DEPTH)
                    sb.push_back({m_ext, m_brk, b});
                m_ext = 0;
                m_brk = 0;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        int n;
        n = 0;
        if (sb.size() == 0) begin
            chk({tag, "_empty"}, rd_valid, 0);
        end else begin
            while (!rd_valid && n < 200) begin
                @(negedge inclock);
                n++;
            end
            chk({tag, "_valid"}, rd_valid, 1);
            chk(tag, rd_data, sb.pop_front());
            rd_en = 1'b1;
            @(negedge inclock);
            rd_en = 1'b0;
        end
    endtask

    task automatic pop_raw(input string tag);
        chk({tag, "_valid"}, rd_valid_raw, 1);
        chk(tag, rd_data_raw, sb_raw.pop_front());
        rd_en_raw = 1'b1;
        @(negedge inclock);
        rd_en_raw = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge inclock);
        err_clear = 1'b1;
        @(negedge inclock);
        err_clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_data"}, rd_data, 0);
        chk({tag, "_cnt"}, fifo_count, 0);
        chk({tag, "_last"}, last_data_received, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_perr"}, parity_err, 0);
        chk({tag, "_ferr"}, frame_err, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge inclock);
        resetn = 1'b1;
        @(negedge inclock);
        chk_all_zero("rst");

        send_frame(8'h1C);
        chk("cnt_1c", fifo_count, 1);
        chk("last_1c", last_data_received, 8'h1C);
        pop_check("data_1c");
        chk("cnt_after_pop", fifo_count, 0);
        chk("valid_after_pop", rd_valid, 0);

        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        chk("cnt_prefix", fifo_count, 1);
        chk("last_prefix", last_data_received, 8'h75);
        chk("raw_cnt", fifo_count_raw, 4);
        pop_check("ext_brk_75");
        while (sb_raw.size() > 0)
            pop_raw("raw_entry");
        chk("raw_cnt0", fifo_count_raw, 0);
        raw_track = 0;

        send_frame(8'h1C, 1);
        chk("perr_set", parity_err, 1);
        chk("perr_nopush", fifo_count, 0);
        chk("perr_noferr", frame_err, 0);
        clear_errs();
        chk("perr_clr", parity_err, 0);
        send_frame(8'h1C, 0, 1'b0);
        chk("ferr_set", frame_err, 1);
        chk("ferr_nopush", fifo_count, 0);
        chk("ferr_last_kept", last_data_received, 8'h75);
        clear_errs();
        chk("ferr_clr", frame_err, 0);

        send_frame(8'hE0);
        send_frame(8'h6B, 1);
        send_frame(8'h6B);
        pop_check("ext_survives_err");
        clear_errs();

        for (int i = 1; i <= 9; i++)
            send_frame(8'(i));
        chk("full_cnt", fifo_count, DEPTH);
        chk("ovf_set", overflow, 1);
        clear_errs();
        chk("ovf_clr", overflow, 0);
        send_frame(8'h0A, 0, 1'b1, 11, 1);
        chk("full_pushpop_cnt", fifo_count, DEPTH);
        chk("full_pushpop_ovf", overflow, 0);
        while (sb.size() > 0)
            pop_check("drain");
        chk("drain_cnt", fifo_count, 0);
        pop_check("drained");

`ifdef PS2_RX_TIMEOUT_EN
        send_frame(8'h55, 0, 1'b1, 4);
        repeat (TO + 20) @(negedge inclock);
        chk("to_ferr", frame_err, 1);
        chk("to_cnt", fifo_count, 0);
        clear_errs();
        send_frame(8'h29);
        pop_check("after_timeout");
`endif

        send_frame(8'h33);
        send_frame(8'h44, 1);
        chk("pre_rst_perr", parity_err, 1);
        send_frame(8'hA5, 0, 1'b1, 5);
        @(negedge inclock);
        resetn = 1'b0;
        #2;
        chk_all_zero("async_rst");
        sb.delete();
        m_ext = 0;
        m_brk = 0;
        ps2_data = 1'b1;
        repeat (2) @(negedge inclock);
        resetn = 1'b1;
        send_frame(8'h5A);
        pop_check("after_rst");

        repeat (5) @(negedge inclock);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
